// File: rtl/i2c_target_model_if.sv
// Wire taps and sideband status shared between the I2C target model and its environment.
interface i2c_target_model_if #(parameter int PW = 4);
    logic          scl_in;
    logic          sda_in;
    logic          sda_oe;
    logic          busy;
    logic          wr_strobe;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_strobe;

    modport slave  (input  scl_in, sda_in,
                    output sda_oe, busy, wr_strobe, wr_addr, wr_data, rd_strobe);
    modport master (output scl_in, sda_in,
                    input  sda_oe, busy, wr_strobe, wr_addr, wr_data, rd_strobe);
endinterface

// File: rtl/i2c_target_model.sv
// I2C target with a small byte register file: address match, ACK, pointer-then-data writes,
// auto-incrementing reads. Oversamples SCL/SDA on core_clk.
module i2c_target_model #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         MEM_DEPTH   = 16
) (
    input logic               core_clk,
    input logic               core_reset,
    i2c_target_model_if.slave bus
);
    localparam int PW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_sda_oe, w_oe_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic          r_rw, w_rw_nxt;
    logic          r_first, w_first_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_wr_strobe, w_wr_stb_nxt;
    logic          r_rd_strobe, w_rd_stb_nxt;
    logic [PW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          w_mem_we;
    logic [7:0]    w_byte;
    logic [7:0]    r_mem [MEM_DEPTH];
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronizers idle high so reset never fakes a START
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            r_scl_s1 <= bus.scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= bus.sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_ptr_inc  = r_ptr + PW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_oe_nxt     = r_sda_oe;
        w_ptr_nxt    = r_ptr;
        w_rw_nxt     = r_rw;
        w_first_nxt  = r_first;
        w_wr_stb_nxt = 1'b0;
        w_rd_stb_nxt = 1'b0;
        w_mem_we     = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE, S_IGNORE: w_oe_nxt = 1'b0;
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_cnt == 4'd7) begin
                        w_cnt_nxt = 4'd0;
                        if (w_byte[7:1] == TARGET_ADDR) begin
                            w_state_nxt = S_ADDR_ACK;
                            w_rw_nxt    = w_byte[0];
                            w_first_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                // cnt 0: waiting for the fall that opens the ACK slot; cnt 1: ACK clock has risen
                S_ADDR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_oe_nxt  = 1'b0;
                            w_cnt_nxt = 4'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                w_state_nxt  = S_RD_BYTE;
                                w_shift_nxt  = r_mem[r_ptr];
                                w_oe_nxt     = ~r_mem[r_ptr][7];
                                w_rd_stb_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_WR_BYTE;
                            end
                        end
                    end else if (w_scl_rise) begin
                        w_cnt_nxt = 4'd1;
                    end
                end
                S_WR_BYTE: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_cnt == 4'd7) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_WR_ACK;
                        if (r_first) begin
                            w_ptr_nxt   = w_byte[PW-1:0];
                            w_first_nxt = 1'b0;
                        end else begin
                            w_mem_we     = 1'b1;
                            w_wr_stb_nxt = 1'b1;
                            w_ptr_nxt    = w_ptr_inc;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                S_RD_BYTE: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = S_RD_ACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!r_sda_s2) begin
                            w_ptr_nxt    = w_ptr_inc;
                            w_shift_nxt  = r_mem[w_ptr_inc];
                            w_rd_stb_nxt = 1'b1;
                            w_cnt_nxt    = 4'd1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_oe_nxt    = ~r_shift[7];
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_RD_BYTE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt == S_ADDR_ACK) || (w_state_nxt == S_WR_BYTE) ||
                     (w_state_nxt == S_WR_ACK)   || (w_state_nxt == S_RD_BYTE) ||
                     (w_state_nxt == S_RD_ACK);
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_oe    <= w_oe_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rw        <= w_rw_nxt;
            r_first     <= w_first_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_strobe <= w_wr_stb_nxt;
            r_rd_strobe <= w_rd_stb_nxt;
            if (w_mem_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    assign bus.sda_oe    = r_sda_oe;
    assign bus.busy      = r_busy;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.rd_strobe = r_rd_strobe;
endmodule

// File: tb/tb_i2c_target_model.sv
// Directed bench for i2c_target_model: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_target_model;
    logic core_clk = 1'b0;
    logic core_reset = 1'b1;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0, rd_cnt = 0, oe_cycles = 0, busy_cycles = 0;
    logic [3:0] wr_a [32];
    logic [7:0] wr_d [32];

    i2c_target_model_if #(.PW(4)) bus ();

    i2c_target_model #(.TARGET_ADDR(7'h50), .MEM_DEPTH(16)) dut (
        .core_clk   (core_clk),
        .core_reset (core_reset),
        .bus        (bus)
    );

    assign bus.scl_in = scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    always #5 core_clk = ~core_clk;

    always @(negedge core_clk) begin
        if (bus.wr_strobe) begin
            wr_a[wr_cnt % 32] = bus.wr_addr;
            wr_d[wr_cnt % 32] = bus.wr_data;
            wr_cnt++;
        end
        if (bus.rd_strobe) rd_cnt++;
        if (bus.sda_oe) oe_cycles++;
        if (bus.busy) busy_cycles++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(10);
        scl = 1'b1;   wait_clks(10);
        m_sda = 1'b0; wait_clks(10);
        scl = 1'b0;   wait_clks(10);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(10);
        scl = 1'b1;   wait_clks(10);
        m_sda = 1'b1; wait_clks(10);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;  wait_clks(10);
        scl = 1'b1; wait_clks(20);
        scl = 1'b0; wait_clks(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_sda = 1'b1; wait_clks(10);
        scl = 1'b1;   wait_clks(10);
        ack = bus.sda_in; wait_clks(10);
        scl = 1'b0;   wait_clks(10);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_clks(10);
            scl = 1'b1; wait_clks(10);
            b = {b[6:0], bus.sda_in}; wait_clks(10);
            scl = 1'b0;
        end
        wait_clks(10);
        m_sda = nack; wait_clks(10);
        scl = 1'b1;   wait_clks(20);
        scl = 1'b0;   wait_clks(10);
    endtask

    task automatic test_reset();
        wait_clks(4);
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got %b want 0", bus.sda_oe); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_vec++; if (bus.wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe got %b want 0", bus.wr_strobe); end
        n_vec++; if (bus.rd_strobe !== 1'b0) begin n_err++; $display("FAIL reset_rd_strobe got %b want 0", bus.rd_strobe); end
        n_vec++; if (bus.wr_addr !== 4'h0) begin n_err++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
        n_vec++; if (bus.wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
        n_vec++; if (dut.r_ptr !== 4'h0) begin n_err++; $display("FAIL reset_ptr got %h want 0", dut.r_ptr); end
        core_reset = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_write();
        logic [7:0] seq [4];
        logic ack;
        int   wb, bb;
        seq[0] = 8'hA0; seq[1] = 8'h03; seq[2] = 8'hA5; seq[3] = 8'h3C;
        wb = wr_cnt; bb = busy_cycles;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], ack);
            n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL write_ack%0d got %b want 0", i, ack); end
        end
        i2c_stop();
        wait_clks(5);
        n_vec++; if (wr_cnt - wb !== 2) begin n_err++; $display("FAIL write_strobes got %0d want 2", wr_cnt - wb); end
        n_vec++; if (wr_a[wb % 32] !== 4'd3 || wr_d[wb % 32] !== 8'hA5) begin n_err++; $display("FAIL write_first got (%0d,%h) want (3,a5)", wr_a[wb % 32], wr_d[wb % 32]); end
        n_vec++; if (wr_a[(wb + 1) % 32] !== 4'd4 || wr_d[(wb + 1) % 32] !== 8'h3C) begin n_err++; $display("FAIL write_second got (%0d,%h) want (4,3c)", wr_a[(wb + 1) % 32], wr_d[(wb + 1) % 32]); end
        n_vec++; if (dut.r_ptr !== 4'd5) begin n_err++; $display("FAIL write_ptr got %0d want 5", dut.r_ptr); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL write_busy_after_stop got %b want 0", bus.busy); end
        n_vec++; if (busy_cycles == bb) begin n_err++; $display("FAIL write_busy_seen got 0 cycles want >0"); end
    endtask

    task automatic test_read_rstart();
        logic ack;
        logic [7:0] d;
        int   rb;
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_waddr_ack got %b want 0", ack); end
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL read_raddr_ack got %b want 0", ack); end
        read_byte(1'b0, d);
        n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL read_byte0 got %h want a5", d); end
        read_byte(1'b1, d);
        n_vec++; if (d !== 8'h3C) begin n_err++; $display("FAIL read_byte1 got %h want 3c", d); end
        wait_clks(5);
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL read_oe_after_nack got %b want 0", bus.sda_oe); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL read_busy_after_nack got %b want 0", bus.busy); end
        n_vec++; if (rd_cnt - rb !== 2) begin n_err++; $display("FAIL read_strobes got %0d want 2", rd_cnt - rb); end
        i2c_stop();
        wait_clks(5);
    endtask

    task automatic test_mismatch();
        logic ack;
        int   wb, rb, ob, bb;
        wb = wr_cnt; rb = rd_cnt; ob = oe_cycles; bb = busy_cycles;
        i2c_start();
        write_byte(8'hA2, ack);
        n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mismatch_addr_ack got %b want 1", ack); end
        write_byte(8'h11, ack);
        i2c_stop();
        wait_clks(5);
        n_vec++; if (oe_cycles != ob) begin n_err++; $display("FAIL mismatch_oe got %0d cycles want 0", oe_cycles - ob); end
        n_vec++; if (busy_cycles != bb) begin n_err++; $display("FAIL mismatch_busy got %0d cycles want 0", busy_cycles - bb); end
        n_vec++; if (wr_cnt != wb || rd_cnt != rb) begin n_err++; $display("FAIL mismatch_strobes got wr %0d rd %0d want 0 0", wr_cnt - wb, rd_cnt - rb); end
        n_vec++; if (dut.r_mem[3] !== 8'hA5 || dut.r_mem[1] !== 8'h00) begin n_err++; $display("FAIL mismatch_mem got %h %h want a5 00", dut.r_mem[3], dut.r_mem[1]); end
    endtask

    task automatic test_wrap();
        logic ack;
        int   wb;
        wb = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrap_ack got %b want 0", ack); end
        i2c_stop();
        wait_clks(5);
        n_vec++; if (dut.r_mem[15] !== 8'h11) begin n_err++; $display("FAIL wrap_mem15 got %h want 11", dut.r_mem[15]); end
        n_vec++; if (dut.r_mem[0] !== 8'h22) begin n_err++; $display("FAIL wrap_mem0 got %h want 22", dut.r_mem[0]); end
        n_vec++; if (dut.r_ptr !== 4'd1) begin n_err++; $display("FAIL wrap_ptr got %0d want 1", dut.r_ptr); end
        n_vec++; if (wr_a[(wb + 1) % 32] !== 4'd0) begin n_err++; $display("FAIL wrap_wr_addr got %0d want 0", wr_a[(wb + 1) % 32]); end
    endtask

    task automatic test_abort();
        logic ack;
        int   wb;
        wb = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        wait_clks(5);
        n_vec++; if (wr_cnt != wb) begin n_err++; $display("FAIL abort_partial_strobe got %0d want 0", wr_cnt - wb); end
        n_vec++; if (dut.r_mem[2] !== 8'h00) begin n_err++; $display("FAIL abort_mem2_partial got %h want 00", dut.r_mem[2]); end
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        write_byte(8'h77, ack);
        i2c_stop();
        wait_clks(5);
        n_vec++; if (wr_cnt - wb !== 1) begin n_err++; $display("FAIL abort_strobe got %0d want 1", wr_cnt - wb); end
        n_vec++; if (dut.r_mem[2] !== 8'h77) begin n_err++; $display("FAIL abort_mem2 got %h want 77", dut.r_mem[2]); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] a;
        logic [7:0] d;
        logic ack;
        a = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        n_vec++; if (bus.sda_oe !== 1'b1) begin n_err++; $display("FAIL rst_ack_driven got %b want 1", bus.sda_oe); end
        core_reset = 1'b1;
        wait_clks(1);
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_ack_release got %b want 0", bus.sda_oe); end
        wait_clks(1);
        core_reset = 1'b0;
        wait_clks(5);
        i2c_stop();
        wait_clks(5);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_raddr_ack got %b want 0", ack); end
        read_byte(1'b1, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_read_mem3 got %h want 00", d); end
        i2c_stop();
        wait_clks(5);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rstart();
        test_mismatch();
        test_wrap();
        test_abort();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
